hazard_ctrl_unit: RTL and testbench

HAZARD_CTRL_UNIT -- requirements
Module: hazard_ctrl_unit

---
 rtl/hazard_pkg.sv | 25 ++
 rtl/hazard_ctrl_unit_fwd_match.sv | 46 ++++
 rtl/hazard_ctrl_unit.sv | 139 +++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_pkg
//  Description : Shared encodings for the pipeline hazard control unit:
//                forward-select codes and branch-wait FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    // Forward-select codes driven per decode-stage operand
    localparam logic [1:0] c_FWD_NONE = 2'b00;
    localparam logic [1:0] c_FWD_WB   = 2'b01;
    localparam logic [1:0] c_FWD_MEM  = 2'b10;

    // Saturation ceiling of the stall performance counter
    localparam logic [15:0] c_STALL_CNT_MAX = 16'hFFFF;

    // Control-flow FSM: normal issue, or waiting for a branch outcome
    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_BR_WAIT = 1'b1
    } hzState_t;

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_unit_fwd_match.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_match
//  Description : Per-operand hazard matcher. Produces the forward select for
//                one decode-stage source and flags a load-use conflict on it.
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_match
    import hazard_pkg::*;
#(
    parameter int REG_AW   = 3,
    parameter int ZERO_REG = 0
) (
    input  logic [REG_AW-1:0] i_srcAddr,
    input  logic              i_srcVld,
    input  logic [REG_AW-1:0] i_exRd,
    input  logic              i_exMemread,
    input  logic [REG_AW-1:0] i_memRd,
    input  logic              i_memRegwrite,
    input  logic [REG_AW-1:0] i_wbRd,
    input  logic              i_wbRegwrite,
    output logic [1:0]        o_fwdSel,
    output logic              o_loadUse
);

    // An operand takes part in hazard detection only if it is really read
    // and is not the hardwired zero register.
    logic w_live;

    // Forward select with MEM over WB priority, plus load-use detection
    always_comb begin
        w_live    = i_srcVld && !((ZERO_REG != 0) && (i_srcAddr == '0));
        o_fwdSel  = c_FWD_NONE;
        o_loadUse = 1'b0;
        if (w_live) begin
            if (i_memRegwrite && (i_srcAddr == i_memRd)) begin
                o_fwdSel = c_FWD_MEM;
            end else if (i_wbRegwrite && (i_srcAddr == i_wbRd)) begin
                o_fwdSel = c_FWD_WB;
            end
            o_loadUse = i_exMemread && (i_srcAddr == i_exRd);
        end
    end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl_unit
//  Description : Pipeline hazard controller: operand forwarding, load-use
//                stall, branch/jump wait with timeout, stall-cycle counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW   = 3,
    parameter int NUM_SRC  = 2,
    parameter int BR_LAT   = 2,
    parameter int ZERO_REG = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_SRC*REG_AW-1:0] src_addr,
    input  logic [NUM_SRC-1:0]        src_vld,
    input  logic [REG_AW-1:0]         ex_rd,
    input  logic                      ex_memread,
    input  logic [REG_AW-1:0]         mem_rd,
    input  logic                      mem_regwrite,
    input  logic [REG_AW-1:0]         wb_rd,
    input  logic                      wb_regwrite,
    input  logic                      branch_d,
    input  logic                      jump_d,
    input  logic                      br_resolved,
    output logic [2*NUM_SRC-1:0]      fwd_sel,
    output logic                      stall_f,
    output logic                      stall_d,
    output logic                      flush_d,
    output logic                      flush_e,
    output logic [15:0]               stall_cnt
);

    localparam logic [3:0] c_BR_LAT = 4'(BR_LAT);

    logic [NUM_SRC-1:0] w_loadUse;
    logic               w_lwHit;

    hzState_t   r_state;
    hzState_t   w_stateNext;
    logic [3:0] r_brCnt;
    logic [3:0] w_brCntNext;
    logic [15:0] r_stallCnt;

    logic w_stallF;
    logic w_stallD;
    logic w_flushD;
    logic w_flushE;

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_fwd
        fwd_match #(
            .REG_AW   (REG_AW),
            .ZERO_REG (ZERO_REG)
        ) u_fwd_match (
            .i_srcAddr     (src_addr[gi*REG_AW +: REG_AW]),
            .i_srcVld      (src_vld[gi]),
            .i_exRd        (ex_rd),
            .i_exMemread   (ex_memread),
            .i_memRd       (mem_rd),
            .i_memRegwrite (mem_regwrite),
            .i_wbRd        (wb_rd),
            .i_wbRegwrite  (wb_regwrite),
            .o_fwdSel      (fwd_sel[gi*2 +: 2]),
            .o_loadUse     (w_loadUse[gi])
        );
    end

    assign w_lwHit = |w_loadUse;

    // Next-state and control outputs; load-use wins over a decode branch,
    // which simply stays held in decode until the load clears.
    always_comb begin
        w_stateNext = r_state;
        w_brCntNext = r_brCnt;
        w_stallF    = 1'b0;
        w_stallD    = 1'b0;
        w_flushD    = 1'b0;
        w_flushE    = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_lwHit) begin
                    w_stallF = 1'b1;
                    w_stallD = 1'b1;
                    w_flushE = 1'b1;
                end else if (branch_d || jump_d) begin
                    w_stateNext = ST_BR_WAIT;
                    w_brCntNext = c_BR_LAT;
                end
            end
            ST_BR_WAIT: begin
                w_stallF    = 1'b1;
                w_flushD    = 1'b1;
                w_brCntNext = r_brCnt - 4'd1;
                // <= 1 also guards against a wait that was never loaded
                if (br_resolved || (r_brCnt <= 4'd1)) begin
                    w_stateNext = ST_RUN;
                    w_brCntNext = 4'd0;
                end
            end
        endcase
        if (reset) begin
            w_stallF = 1'b0;
            w_stallD = 1'b0;
            w_flushD = 1'b0;
            w_flushE = 1'b0;
        end
    end

    // FSM state and branch-wait countdown
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_brCnt <= 4'd0;
        end else begin
            r_state <= w_stateNext;
            r_brCnt <= w_brCntNext;
        end
    end

    // Saturating count of cycles in which the PC is held
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stallCnt <= 16'd0;
        end else if (w_stallF && (r_stallCnt != c_STALL_CNT_MAX)) begin
            r_stallCnt <= r_stallCnt + 16'd1;
        end
    end

    assign stall_f   = w_stallF;
    assign stall_d   = w_stallD;
    assign flush_d   = w_flushD;
    assign flush_e   = w_flushE;
    assign stall_cnt = r_stallCnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl_unit
//  Description : Self-checking bench for hazard_ctrl_unit. Two instances
//                share stimulus: [0] BR_LAT=2/ZERO_REG=0, [1] BR_LAT=4/ZERO_REG=1.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] src_addr;
    logic [1:0] src_vld;
    logic [2:0] ex_rd;
    logic       ex_memread;
    logic [2:0] mem_rd;
    logic       mem_regwrite;
    logic [2:0] wb_rd;
    logic       wb_regwrite;
    logic       branch_d;
    logic       jump_d;
    logic       br_resolved;

    logic [3:0]  fwdSel   [2];
    logic        stallF   [2];
    logic        stallD   [2];
    logic        flushD   [2];
    logic        flushE   [2];
    logic [15:0] stallCnt [2];
    logic [3:0]  ctl      [2];

    int total = 0;
    int bad   = 0;

    // Reference model state: remaining branch-wait cycles and stall count
    int waitLeft [2] = '{0, 0};
    int stalls   [2] = '{0, 0};
    int LAT      [2] = '{2, 4};
    bit ZR       [2] = '{1'b0, 1'b1};

    always #5 clk = ~clk;

    hazard_ctrl_unit #(.REG_AW(3), .NUM_SRC(2), .BR_LAT(2), .ZERO_REG(0)) dutA (
        .clk(clk), .reset(reset), .src_addr(src_addr), .src_vld(src_vld),
        .ex_rd(ex_rd), .ex_memread(ex_memread), .mem_rd(mem_rd),
        .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .branch_d(branch_d), .jump_d(jump_d), .br_resolved(br_resolved),
        .fwd_sel(fwdSel[0]), .stall_f(stallF[0]), .stall_d(stallD[0]),
        .flush_d(flushD[0]), .flush_e(flushE[0]), .stall_cnt(stallCnt[0])
    );

    hazard_ctrl_unit #(.REG_AW(3), .NUM_SRC(2), .BR_LAT(4), .ZERO_REG(1)) dutB (
        .clk(clk), .reset(reset), .src_addr(src_addr), .src_vld(src_vld),
        .ex_rd(ex_rd), .ex_memread(ex_memread), .mem_rd(mem_rd),
        .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .branch_d(branch_d), .jump_d(jump_d), .br_resolved(br_resolved),
        .fwd_sel(fwdSel[1]), .stall_f(stallF[1]), .stall_d(stallD[1]),
        .flush_d(flushD[1]), .flush_e(flushE[1]), .stall_cnt(stallCnt[1])
    );

    // Control outputs packed as {stall_f, stall_d, flush_d, flush_e}
    assign ctl[0] = {stallF[0], stallD[0], flushD[0], flushE[0]};
    assign ctl[1] = {stallF[1], stallD[1], flushD[1], flushE[1]};

    // ---------------- reference model ----------------
    function automatic logic excluded(int k, logic [2:0] a);
        return ZR[k] && (a == 3'd0);
    endfunction

    function automatic logic [3:0] fwdExp(int k);
        logic [3:0] r;
        logic [2:0] a;
        r = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            a = src_addr[i*3 +: 3];
            if (src_vld[i] && !excluded(k, a)) begin
                if (mem_regwrite && a == mem_rd)     r[i*2 +: 2] = 2'b10;
                else if (wb_regwrite && a == wb_rd)  r[i*2 +: 2] = 2'b01;
            end
        end
        return r;
    endfunction

    function automatic logic hitExp(int k);
        logic [2:0] a;
        logic h;
        h = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a = src_addr[i*3 +: 3];
            if (ex_memread && src_vld[i] && !excluded(k, a) && a == ex_rd) h = 1'b1;
        end
        return h;
    endfunction

    function automatic logic [3:0] ctlExp(int k);
        if (reset)            return 4'b0000;
        if (waitLeft[k] > 0)  return 4'b1010;
        if (hitExp(k))        return 4'b1101;
        return 4'b0000;
    endfunction

    task automatic modelAdvance();
        logic [3:0] c;
        for (int k = 0; k < 2; k++) begin
            c = ctlExp(k);
            if (reset) begin
                waitLeft[k] = 0;
                stalls[k]   = 0;
            end else begin
                if (c[3] && stalls[k] < 65535) stalls[k]++;
                if (waitLeft[k] > 0)
                    waitLeft[k] = (br_resolved || waitLeft[k] == 1) ? 0 : waitLeft[k] - 1;
                else if (!hitExp(k) && (branch_d || jump_d))
                    waitLeft[k] = LAT[k];
            end
        end
    endtask

    // One clock: model consumes the inputs present at the edge
    task automatic tick();
        @(posedge clk);
        modelAdvance();
        #1;
    endtask

    task automatic idle();
        src_addr = '0; src_vld = '0; ex_rd = '0; ex_memread = 0;
        mem_rd = '0; mem_regwrite = 0; wb_rd = '0; wb_regwrite = 0;
        branch_d = 0; jump_d = 0; br_resolved = 0;
    endtask

    task automatic doReset();
        idle();
        reset = 1;
        tick();
        reset = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle();
        reset = 1;
        src_addr = 6'd3; src_vld = 2'b01; mem_rd = 3'd3; mem_regwrite = 1;
        ex_memread = 1; ex_rd = 3'd3; branch_d = 1;
        #4;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (ctl[k] !== 4'b0000) begin bad++; $display("FAIL rst_ctl[%0d] got=%b want=0000", k, ctl[k]); end
            total++;
            if (fwdSel[k] !== 4'b0010) begin bad++; $display("FAIL rst_fwd[%0d] got=%b want=0010", k, fwdSel[k]); end
        end
        tick();
        idle();
        reset = 0;
        #4;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (stallCnt[k] !== 16'd0) begin bad++; $display("FAIL rst_cnt[%0d] got=%0d want=0", k, stallCnt[k]); end
            total++;
            if (ctl[k] !== 4'b0000) begin bad++; $display("FAIL rst_run[%0d] got=%b want=0000", k, ctl[k]); end
        end
        tick();
    endtask

    task automatic test_fwd_priority();
        doReset();
        src_addr = {3'd0, 3'd3}; src_vld = 2'b01;
        mem_rd = 3'd3; wb_rd = 3'd3; mem_regwrite = 1; wb_regwrite = 1;
        #4;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (fwdSel[k] !== 4'b0010) begin bad++; $display("FAIL fwd_mem[%0d] got=%b want=0010", k, fwdSel[k]); end
        end
        mem_regwrite = 0;
        #1;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (fwdSel[k] !== 4'b0001) begin bad++; $display("FAIL fwd_wb[%0d] got=%b want=0001", k, fwdSel[k]); end
        end
        src_vld = 2'b00;
        #1;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (fwdSel[k] !== 4'b0000) begin bad++; $display("FAIL fwd_novld[%0d] got=%b want=0000", k, fwdSel[k]); end
        end
        tick();
    endtask

    task automatic test_zero_reg();
        doReset();
        src_addr = {3'd0, 3'd6}; src_vld = 2'b10;
        mem_rd = 3'd0; mem_regwrite = 1; ex_memread = 1; ex_rd = 3'd0;
        #4;
        total++;
        if (fwdSel[1][3:2] !== 2'b00) begin bad++; $display("FAIL zr_fwdB got=%b want=00", fwdSel[1][3:2]); end
        total++;
        if (ctl[1] !== 4'b0000) begin bad++; $display("FAIL zr_ctlB got=%b want=0000", ctl[1]); end
        total++;
        if (fwdSel[0][3:2] !== 2'b10) begin bad++; $display("FAIL zr_fwdA got=%b want=10", fwdSel[0][3:2]); end
        total++;
        if (ctl[0] !== 4'b1101) begin bad++; $display("FAIL zr_ctlA got=%b want=1101", ctl[0]); end
        tick();
    endtask

    task automatic test_load_use();
        doReset();
        ex_memread = 1; ex_rd = 3'd5; src_addr = {3'd5, 3'd0}; src_vld = 2'b10;
        #4;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (ctl[k] !== 4'b1101) begin bad++; $display("FAIL lu_ctl[%0d] got=%b want=1101", k, ctl[k]); end
        end
        tick();
        idle();
        #4;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (ctl[k] !== 4'b0000) begin bad++; $display("FAIL lu_after[%0d] got=%b want=0000", k, ctl[k]); end
            total++;
            if (stallCnt[k] !== 16'd1) begin bad++; $display("FAIL lu_cnt[%0d] got=%0d want=1", k, stallCnt[k]); end
        end
        tick();
    endtask

    task automatic test_branch_timeout();
        logic [3:0] want;
        doReset();
        branch_d = 1;
        #4;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (ctl[k] !== 4'b0000) begin bad++; $display("FAIL bt_entry[%0d] got=%b want=0000", k, ctl[k]); end
        end
        tick();
        branch_d = 0;
        for (int c = 1; c <= 5; c++) begin
            #4;
            for (int k = 0; k < 2; k++) begin
                want = (c <= LAT[k]) ? 4'b1010 : 4'b0000;
                total++;
                if (ctl[k] !== want) begin bad++; $display("FAIL bt_c%0d[%0d] got=%b want=%b", c, k, ctl[k], want); end
            end
            tick();
        end
        #4;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (stallCnt[k] !== 16'(LAT[k])) begin bad++; $display("FAIL bt_cnt[%0d] got=%0d want=%0d", k, stallCnt[k], LAT[k]); end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        doReset();
        ex_memread = 1; ex_rd = 3'd5; src_addr = {3'd5, 3'd0}; src_vld = 2'b10; jump_d = 1;
        #4;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (ctl[k] !== 4'b1101) begin bad++; $display("FAIL col_lu[%0d] got=%b want=1101", k, ctl[k]); end
        end
        tick();
        ex_memread = 0;
        #4;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (ctl[k] !== 4'b0000) begin bad++; $display("FAIL col_entry[%0d] got=%b want=0000", k, ctl[k]); end
        end
        tick();
        jump_d = 0; br_resolved = 1;
        #4;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (ctl[k] !== 4'b1010) begin bad++; $display("FAIL col_wait[%0d] got=%b want=1010", k, ctl[k]); end
        end
        tick();
        br_resolved = 0;
        #4;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (ctl[k] !== 4'b0000) begin bad++; $display("FAIL col_run[%0d] got=%b want=0000", k, ctl[k]); end
            total++;
            if (stallCnt[k] !== 16'd2) begin bad++; $display("FAIL col_cnt[%0d] got=%0d want=2", k, stallCnt[k]); end
        end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        doReset();
        branch_d = 1;
        tick();
        branch_d = 0;
        #4;
        total++;
        if (ctl[1] !== 4'b1010) begin bad++; $display("FAIL rmw_w1 got=%b want=1010", ctl[1]); end
        tick();
        reset = 1;
        #4;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (ctl[k] !== 4'b0000) begin bad++; $display("FAIL rmw_inrst[%0d] got=%b want=0000", k, ctl[k]); end
        end
        tick();
        reset = 0;
        #4;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (ctl[k] !== 4'b0000) begin bad++; $display("FAIL rmw_run[%0d] got=%b want=0000", k, ctl[k]); end
            total++;
            if (stallCnt[k] !== 16'd0) begin bad++; $display("FAIL rmw_cnt[%0d] got=%0d want=0", k, stallCnt[k]); end
        end
        tick();
    endtask

    task automatic test_random();
        logic [3:0] want;
        for (int n = 0; n < 500; n++) begin
            reset        = ($urandom_range(0, 49) == 0);
            src_addr     = {1'b0, 2'($urandom), 1'b0, 2'($urandom)};
            src_vld      = 2'($urandom);
            ex_rd        = 3'($urandom_range(0, 3));
            ex_memread   = ($urandom_range(0, 2) == 0);
            mem_rd       = 3'($urandom_range(0, 3));
            mem_regwrite = 1'($urandom);
            wb_rd        = 3'($urandom_range(0, 3));
            wb_regwrite  = 1'($urandom);
            branch_d     = ($urandom_range(0, 4) == 0);
            jump_d       = ($urandom_range(0, 7) == 0);
            br_resolved  = ($urandom_range(0, 3) == 0);
            #4;
            for (int k = 0; k < 2; k++) begin
                want = ctlExp(k);
                total++;
                if (ctl[k] !== want) begin bad++; $display("FAIL rnd_ctl[%0d] n=%0d got=%b want=%b", k, n, ctl[k], want); end
                want = fwdExp(k);
                total++;
                if (fwdSel[k] !== want) begin bad++; $display("FAIL rnd_fwd[%0d] n=%0d got=%b want=%b", k, n, fwdSel[k], want); end
                total++;
                if (stallCnt[k] !== 16'(stalls[k])) begin bad++; $display("FAIL rnd_cnt[%0d] n=%0d got=%0d want=%0d", k, n, stallCnt[k], stalls[k]); end
            end
            tick();
        end
        reset = 0;
    endtask

    initial begin
        idle();
        reset = 1;
        test_reset();
        test_fwd_priority();
        test_zero_reg();
        test_load_use();
        test_branch_timeout();
        test_back_to_back();
        test_reset_mid_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
